thirty_two_bit_adder: RTL and testbench
=======================================

# thirty_two_bit_adder

Registered 32-bit binary adder with carry-in and carry-out, the add/subtract datapath core of the 32-bit ALU. It adds two unsigned 32-bit operands plus a 1-bit carry-in. The sum is computed through a two-level carry-lookahead structure and presented one clock later with carry-out, signed-overflow and a valid flag. Subtraction is done upstream by the ALU, which inverts B and sets Cin=1.

## Interface
- No parameters; the width is fixed at 32.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous and active-low.
- A  input  32  operand A, unsigned.
- B  input  32  operand B, unsigned.
- Cin  input  1  carry-in. Wider drivers truncate to the LSB, so 653 becomes 1.
- in_valid  input  1  qualifies A, B and Cin for capture on this edge.
- S  output  32  registered sum bits [31:0].
- Cout  output  1  registered carry out of bit 31.
- V  output  1  registered two's-complement overflow.
- out_valid  output  1  high for one cycle when S, Cout and V hold a new result.

## Operation
- Result: {Cout,S} = A + B + Cin, computed as a 33-bit unsigned sum. There is no saturation; the sum wraps modulo 2^32 and bit 32 goes to Cout.
- Overflow: V = (A[31] == B[31]) && (S[31] != A[31]), evaluated on the same operands.
- Datapath structure:
  - Eight 4-bit lookahead groups. Each bit computes p_i = A_i ^ B_i and g_i = A_i & B_i.
  - Each group produces group propagate P and group generate G.
  - A second-level lookahead unit computes the carry into each group from Cin and the group P/G values.
  - Sum bit s_i = p_i ^ c_i.
- Structure is an implementation requirement, not visible at the ports. The result must be bit-identical to a behavioural 33-bit add.
- Capture: on a clock edge with rst_n=1 and in_valid=1, register S, Cout and V, and set out_valid=1.
- Hold: on an edge with rst_n=1 and in_valid=0, S, Cout and V keep their previous values and out_valid=0.
- No internal state exists beyond the output registers. There is no FSM.

## Timing
- Latency: exactly 1 cycle. Operands valid before edge N produce results valid after edge N, with out_valid high during cycle N+1.
- Throughput: one add per cycle. Back-to-back in_valid pulses give back-to-back out_valid pulses.
- Reset: when rst_n=0 at a rising edge, S=0, Cout=0, V=0 and out_valid=0. Reset takes priority over in_valid on that edge.
- Reset mid-stream: any result in flight is discarded and no out_valid is issued for it. Operands presented on the first edge with rst_n=1 are captured normally.
- The combinational path A/B/Cin to the register D inputs must settle within one clock period. The design has no multicycle paths.

## Test plan
- Reset: hold rst_n=0 for 2 edges with in_valid=1, A=5, B=7 -> S=0, Cout=0, V=0, out_valid=0. Release reset -> the first captured result appears one cycle later.
- Basic sums, back-to-back, each result one cycle after input:
  - 0+0+0 -> S=0.
  - 2+5+1 -> S=8.
  - 15+45+0 -> S=60.
  - 20+13+1 -> S=34.
  - 500+16335+0 -> S=16835.
  - 40000+429496+0 -> S=469496.
  - 42949672+5+1 -> S=42949678.
  - All of these give Cout=0.
- Carry-out: A=B=0xFFFFFFFF, Cin=0 -> S=0xFFFFFFFE, Cout=1, V=0. A=0xFFFFFFFF, B=0, Cin=1 -> S=0, Cout=1, V=0; this ripples the carry through all 8 groups.
- Overflow: A=0x7FFFFFFF, B=1, Cin=0 -> S=0x80000000, Cout=0, V=1. A=B=0x80000000 -> S=0, Cout=1, V=1.
- Cin truncation: drive Cin from a wide value 653 with A=86113, B=0 -> S=86114.
- Hold and random: deassert in_valid while changing A/B -> outputs unchanged and out_valid=0. Then run 10k random operand/carry vectors checked against a 33-bit reference sum and the V equation.

Source files
------------

// File: rtl/thirty_two_bit_adder_if.sv
// ----------------------------------------------------------------------------
// thirty_two_bit_adder_if
//
// Bundles the operand/result signals of the registered 32-bit adder.
//   master : ALU side. Drives A, B, Cin and in_valid, and receives the result.
//   slave  : Adder side. Receives the operands and drives S, Cout, V and out_valid.
//
// Signals
//   A, B       32  unsigned operands
//   Cin         1  carry-in
//   in_valid    1  qualifies A/B/Cin for capture on the next rising edge
//   S          32  registered sum
//   Cout        1  registered carry out of bit 31
//   V           1  registered two's-complement overflow
//   out_valid   1  one-cycle strobe marking a new result
// ----------------------------------------------------------------------------
interface thirty_two_bit_adder_if;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cin;
    logic        in_valid;
    logic [31:0] S;
    logic        Cout;
    logic        V;
    logic        out_valid;

    modport master (
        output A,
        output B,
        output Cin,
        output in_valid,
        input  S,
        input  Cout,
        input  V,
        input  out_valid
    );

    modport slave (
        input  A,
        input  B,
        input  Cin,
        input  in_valid,
        output S,
        output Cout,
        output V,
        output out_valid
    );
endinterface

// File: rtl/thirty_two_bit_adder.sv
// ----------------------------------------------------------------------------
// thirty_two_bit_adder
//
// Registered 32-bit adder with carry-in and carry-out. This is the add/subtract
// core of the ALU; subtraction is formed upstream by inverting B and setting
// Cin. The sum is produced by a two-level carry-lookahead network: eight 4-bit
// groups, each reporting a group propagate/generate, and a second-level unit
// that forms the carry into every group directly from Cin and those group
// terms. Results are registered, so they appear one clock after capture.
//
// Ports
//   clk    1  rising-edge clock
//   rst_n  1  synchronous, active-low reset
//   bus       thirty_two_bit_adder_if.slave (operands in, result out)
// ----------------------------------------------------------------------------
module thirty_two_bit_adder (
    input  logic                        clk,
    input  logic                        rst_n,
    thirty_two_bit_adder_if.slave       bus
);

    localparam int unsigned Width     = 32;
    localparam int unsigned GroupBits = 4;
    localparam int unsigned NumGroups = Width / GroupBits;

    // ------------------------------------------------------------------
    // Bit-level propagate / generate
    // ------------------------------------------------------------------
    logic [Width-1:0] p;
    logic [Width-1:0] g;

    assign p = bus.A ^ bus.B;
    assign g = bus.A & bus.B;

    // ------------------------------------------------------------------
    // First level: group propagate / generate for each 4-bit group.
    //   P = p3 p2 p1 p0
    //   G = g3 | p3 g2 | p3 p2 g1 | p3 p2 p1 g0
    // ------------------------------------------------------------------
    logic [NumGroups-1:0] grp_p;
    logic [NumGroups-1:0] grp_g;

    always_comb begin
        logic term;
        grp_p = '0;
        grp_g = '0;
        term  = 1'b0;
        for (int k = 0; k < NumGroups; k++) begin
            grp_p[k] = 1'b1;
            for (int i = 0; i < GroupBits; i++) begin
                grp_p[k] = grp_p[k] & p[k*GroupBits + i];
            end
            for (int i = 0; i < GroupBits; i++) begin
                term = g[k*GroupBits + i];
                for (int m = i + 1; m < GroupBits; m++) begin
                    term = term & p[k*GroupBits + m];
                end
                grp_g[k] = grp_g[k] | term;
            end
        end
    end

    // ------------------------------------------------------------------
    // Second level: carry into each group, flattened sum-of-products so no
    // group waits on its neighbour. grp_c[NumGroups] is the carry out of
    // bit 31.
    //   grp_c[k] = Cin & P[k-1..0]  |  OR_j ( G[j] & P[k-1..j+1] )
    // ------------------------------------------------------------------
    logic [NumGroups:0] grp_c;

    always_comb begin
        logic term;
        grp_c = '0;
        term  = 1'b0;
        for (int k = 0; k <= NumGroups; k++) begin
            term = bus.Cin;
            for (int m = 0; m < k; m++) begin
                term = term & grp_p[m];
            end
            grp_c[k] = term;
            for (int j = 0; j < k; j++) begin
                term = grp_g[j];
                for (int m = j + 1; m < k; m++) begin
                    term = term & grp_p[m];
                end
                grp_c[k] = grp_c[k] | term;
            end
        end
    end

    // ------------------------------------------------------------------
    // In-group lookahead: carry into every bit from the group carry-in and
    // the bit-level terms of the lower bits of that group.
    // ------------------------------------------------------------------
    logic [Width-1:0] c;

    always_comb begin
        logic term;
        c    = '0;
        term = 1'b0;
        for (int k = 0; k < NumGroups; k++) begin
            for (int i = 0; i < GroupBits; i++) begin
                term = grp_c[k];
                for (int m = 0; m < i; m++) begin
                    term = term & p[k*GroupBits + m];
                end
                c[k*GroupBits + i] = term;
                for (int j = 0; j < i; j++) begin
                    term = g[k*GroupBits + j];
                    for (int m = j + 1; m < i; m++) begin
                        term = term & p[k*GroupBits + m];
                    end
                    c[k*GroupBits + i] = c[k*GroupBits + i] | term;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sum, carry out and signed overflow
    // ------------------------------------------------------------------
    logic [Width-1:0] sum_d;
    logic             cout_d;
    logic             v_d;

    assign sum_d  = p ^ c;
    assign cout_d = grp_c[NumGroups];
    // Overflow: operands share a sign and the result sign differs from it.
    assign v_d    = (bus.A[Width-1] == bus.B[Width-1]) && (sum_d[Width-1] != bus.A[Width-1]);

    // ------------------------------------------------------------------
    // Output registers. Reset wins over in_valid; without in_valid the
    // result registers hold and only the strobe drops.
    // ------------------------------------------------------------------
    logic [Width-1:0] s_q;
    logic             cout_q;
    logic             v_q;
    logic             out_valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q         <= '0;
            cout_q      <= 1'b0;
            v_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (bus.in_valid) begin
            s_q         <= sum_d;
            cout_q      <= cout_d;
            v_q         <= v_d;
            out_valid_q <= 1'b1;
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.S         = s_q;
    assign bus.Cout      = cout_q;
    assign bus.V         = v_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_thirty_two_bit_adder.sv
// ----------------------------------------------------------------------------
// tb_thirty_two_bit_adder
//
// Directed and random checks of the registered 32-bit adder. Inputs change on
// the falling edge; outputs are sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_thirty_two_bit_adder;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    thirty_two_bit_adder_if ifc ();

    thirty_two_bit_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operand set with in_valid high, wait for the capturing edge.
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic cin);
        @(negedge clk);
        ifc.A        = a;
        ifc.B        = b;
        ifc.Cin      = cin;
        ifc.in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        ifc.A        = 32'd5;
        ifc.B        = 32'd7;
        ifc.Cin      = 1'b0;
        ifc.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({ifc.S, ifc.Cout, ifc.V, ifc.out_valid} !== 35'd0) begin
            bad++;
            $display("FAIL reset_state: got S=%h Cout=%b V=%b ov=%b want all zero",
                     ifc.S, ifc.Cout, ifc.V, ifc.out_valid);
        end
        // Release: first capture shows up after the next edge.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (ifc.S !== 32'd12 || ifc.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: got S=%0d ov=%b want S=12 ov=1", ifc.S, ifc.out_valid);
        end
        // Reset mid-stream discards the in-flight operands.
        @(negedge clk);
        rst_n = 1'b0;
        ifc.A = 32'd1;
        ifc.B = 32'd2;
        @(posedge clk);
        #1;
        total++;
        if (ifc.S !== 32'd0 || ifc.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_midstream: got S=%0d ov=%b want S=0 ov=0", ifc.S, ifc.out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ifc.A = 32'd3;
        ifc.B = 32'd4;
        @(posedge clk);
        #1;
        total++;
        if (ifc.S !== 32'd7 || ifc.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_capture: got S=%0d ov=%b want S=7 ov=1",
                     ifc.S, ifc.out_valid);
        end
    endtask

    // Back-to-back basic sums; in_valid stays high throughout.
    task automatic test_basic();
        logic [31:0] va [7];
        logic [31:0] vb [7];
        logic        vc [7];
        logic [31:0] vs [7];
        va = '{32'd0, 32'd2, 32'd15, 32'd20, 32'd500,   32'd40000,  32'd42949672};
        vb = '{32'd0, 32'd5, 32'd45, 32'd13, 32'd16335, 32'd429496, 32'd5};
        vc = '{1'b0,  1'b1,  1'b0,   1'b1,   1'b0,      1'b0,       1'b1};
        vs = '{32'd0, 32'd8, 32'd60, 32'd34, 32'd16835, 32'd469496, 32'd42949678};
        for (int i = 0; i < 7; i++) begin
            apply(va[i], vb[i], vc[i]);
            total++;
            if (ifc.S !== vs[i] || ifc.Cout !== 1'b0 || ifc.V !== 1'b0 || ifc.out_valid !== 1'b1) begin
                bad++;
                $display("FAIL basic_%0d: got S=%0d Cout=%b V=%b ov=%b want S=%0d Cout=0 V=0 ov=1",
                         i, ifc.S, ifc.Cout, ifc.V, ifc.out_valid, vs[i]);
            end
        end
    endtask

    task automatic test_carry();
        apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        total++;
        if (ifc.S !== 32'hFFFF_FFFE || ifc.Cout !== 1'b1 || ifc.V !== 1'b0) begin
            bad++;
            $display("FAIL carry_max: got S=%h Cout=%b V=%b want S=fffffffe Cout=1 V=0",
                     ifc.S, ifc.Cout, ifc.V);
        end
        apply(32'hFFFF_FFFF, 32'h0, 1'b1);
        total++;
        if (ifc.S !== 32'h0 || ifc.Cout !== 1'b1 || ifc.V !== 1'b0) begin
            bad++;
            $display("FAIL carry_ripple: got S=%h Cout=%b V=%b want S=00000000 Cout=1 V=0",
                     ifc.S, ifc.Cout, ifc.V);
        end
    endtask

    task automatic test_overflow();
        apply(32'h7FFF_FFFF, 32'h1, 1'b0);
        total++;
        if (ifc.S !== 32'h8000_0000 || ifc.Cout !== 1'b0 || ifc.V !== 1'b1) begin
            bad++;
            $display("FAIL overflow_pos: got S=%h Cout=%b V=%b want S=80000000 Cout=0 V=1",
                     ifc.S, ifc.Cout, ifc.V);
        end
        apply(32'h8000_0000, 32'h8000_0000, 1'b0);
        total++;
        if (ifc.S !== 32'h0 || ifc.Cout !== 1'b1 || ifc.V !== 1'b1) begin
            bad++;
            $display("FAIL overflow_neg: got S=%h Cout=%b V=%b want S=00000000 Cout=1 V=1",
                     ifc.S, ifc.Cout, ifc.V);
        end
    endtask

    task automatic test_cin_trunc();
        logic [31:0] wide;
        wide = 32'd653;
        apply(32'd86113, 32'd0, wide[0]);
        total++;
        if (ifc.S !== 32'd86114 || ifc.Cout !== 1'b0) begin
            bad++;
            $display("FAIL cin_trunc: got S=%0d Cout=%b want S=86114 Cout=0", ifc.S, ifc.Cout);
        end
    endtask

    task automatic test_hold();
        apply(32'd100, 32'd200, 1'b0);
        total++;
        if (ifc.S !== 32'd300 || ifc.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL hold_setup: got S=%0d ov=%b want S=300 ov=1", ifc.S, ifc.out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ifc.in_valid = 1'b0;
            ifc.A        = 32'h8000_0000 + 32'(i);
            ifc.B        = 32'hFFFF_FFFF;
            ifc.Cin      = 1'b1;
            @(posedge clk);
            #1;
            total++;
            if (ifc.S !== 32'd300 || ifc.Cout !== 1'b0 || ifc.V !== 1'b0 ||
                ifc.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL hold_%0d: got S=%0d Cout=%b V=%b ov=%b want S=300 Cout=0 V=0 ov=0",
                         i, ifc.S, ifc.Cout, ifc.V, ifc.out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        cin;
        logic [32:0] ref_sum;
        logic        ref_v;
        for (int i = 0; i < 10000; i++) begin
            a   = $urandom();
            b   = $urandom();
            r   = $urandom();
            cin = r[0];
            ref_sum = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            ref_v   = (a[31] == b[31]) && (ref_sum[31] != a[31]);
            apply(a, b, cin);
            total++;
            if ({ifc.Cout, ifc.S} !== ref_sum || ifc.V !== ref_v || ifc.out_valid !== 1'b1) begin
                bad++;
                $display("FAIL random_%0d: A=%h B=%h Cin=%b got Cout=%b S=%h V=%b ov=%b want Cout=%b S=%h V=%b ov=1",
                         i, a, b, cin, ifc.Cout, ifc.S, ifc.V, ifc.out_valid,
                         ref_sum[32], ref_sum[31:0], ref_v);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_carry();
        test_overflow();
        test_cin_trunc();
        test_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
